// File: rtl/pipe_pkg.sv
// Shared types, constants and helpers for the pipeline stage register.
package pipe_pkg;

  // Occupancy of a stage register: nothing held, main entry only, main + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // RV32I canonical NOP (addi x0, x0, 0), used as the bubble payload.
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // Widest event counter the saturating helper can handle.
  localparam int unsigned MAX_CNT_W = 64;

  // Increment value by one, holding at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] max_v;
    if (width >= MAX_CNT_W) max_v = '1;
    else                    max_v = (64'd1 << width) - 64'd1;
    sat_inc = (value >= max_v) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between two pipeline stages, plus flush.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int unsigned N = 32
);
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_ready;
  logic         flush;

  // Driver side: supplies upstream payloads, downstream ready and flush.
  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data
  );

  // Stage register side.
  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: bump on an event, clamped at the maximum.
  always_comb begin
    count_d = count_q;
    if (inc) count_d = CNT_W'(sat_inc(64'(count_q), CNT_W));
  end

  // Counter register, falling-edge, cleared by the active-low async reset.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid
// buffer, synchronous flush with bubble insertion, and stall/flush counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned N      = 32,
  parameter logic [31:0] BUBBLE = RV_NOP,
  parameter int          SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_stage_reg_if.slave  bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Bubble pattern adapted to the payload width (truncate or zero-extend).
  localparam logic [N-1:0] BUBBLE_N = N'(BUBBLE);

  state_e       state_q;
  state_e       state_d;
  logic [N-1:0] main_q;
  logic [N-1:0] main_d;
  logic         in_ready_w;
  logic         out_valid_w;
  logic         in_fire;
  logic         out_fire;

  assign out_valid_w = (state_q != EMPTY);
  assign out_fire    = out_valid_w && bus.out_ready;
  // Flush wins over an incoming payload: it is never captured.
  assign in_fire     = bus.in_valid && in_ready_w && !bus.flush;

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = out_valid_w ? main_q : BUBBLE_N;

  generate
    if (SKID != 0) begin : g_skid
      logic [N-1:0] skid_q;
      logic [N-1:0] skid_d;

      // Ready comes straight from the state register, so it never depends on
      // out_ready within the same cycle.
      assign in_ready_w = (state_q != TWO);

      // Next-state and entry loading for the two-entry buffer.
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
          EMPTY: begin
            if (in_fire) begin
              state_d = ONE;
              main_d  = bus.in_data;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_d = bus.in_data;
            end else if (out_fire) begin
              state_d = EMPTY;
            end else if (in_fire) begin
              state_d = TWO;
              skid_d  = bus.in_data;
            end
          end
          TWO: begin
            if (out_fire) begin
              state_d = ONE;
              main_d  = skid_q;
            end
          end
          default: state_d = EMPTY;
        endcase
        if (bus.flush) state_d = EMPTY;
      end

      // Skid entry register.
      always_ff @(negedge clk or negedge reset) begin
        if (!reset) skid_q <= '0;
        else        skid_q <= skid_d;
      end
    end else begin : g_noskid
      // Single entry: accept when empty or when the held payload leaves now.
      assign in_ready_w = (state_q == EMPTY) || bus.out_ready;

      // Next-state and main entry loading for the single-entry stage.
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        case (state_q)
          EMPTY: begin
            if (in_fire) begin
              state_d = ONE;
              main_d  = bus.in_data;
            end
          end
          ONE: begin
            if (in_fire) begin
              main_d = bus.in_data;
            end else if (out_fire) begin
              state_d = EMPTY;
            end
          end
          default: state_d = EMPTY;
        endcase
        if (bus.flush) state_d = EMPTY;
      end
    end
  endgenerate

  // State and main entry registers.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  // A stall is a held payload that downstream refuses; a flush edge only counts
  // if it actually killed something.
  logic stall_inc;
  logic flush_inc;
  assign stall_inc = out_valid_w && !bus.out_ready && !bus.flush;
  assign flush_inc = bus.flush && out_valid_w;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed enable-only stage registers between IF/ID, ID/EX, EX/MEM and MEM/WB. It adds a valid/ready handshake, a two-entry skid buffer so backpressure never drops an instruction, synchronous flush with bubble insertion, and saturating stall and flush event counters for performance analysis. One instance sits at each stage boundary of the pipelined core.

## Interface
- N, 32, payload width in bits
- BUBBLE, 32'h0000_0013, payload driven while out_valid=0 (RV32I NOP, addi x0,x0,0); truncated or zero-extended to N
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
- CNT_W, 16, width of each event counter

- clk  input  1  clock; all state updates on the falling edge
- reset  input  1  reset, asynchronous, active-low
- in_valid  input  1  upstream payload valid
- in_data  input  N  upstream payload
- in_ready  output  1  stage can accept a payload this cycle
- out_valid  output  1  downstream payload valid
- out_data  output  N  downstream payload; equals BUBBLE whenever out_valid=0
- out_ready  input  1  downstream accepts a payload this cycle
- flush  input  1  synchronous kill of all held and incoming payloads
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- flush_cnt  output  CNT_W  flushes that killed at least one valid entry, saturating

## Operation
- A transfer happens on an edge where valid=1 and ready=1 on that side. in_data is captured only on an accepted input.
- Storage consists of a main entry, which drives out_data, and a skid entry (present only when SKID=1).
- States (SKID=1) and transitions:
  - EMPTY:
    - an accepted input goes to ONE.
  - ONE:
    - input and output together, or neither: stay in ONE. The main entry is reloaded when input and output occur together.
    - output only: go to EMPTY.
    - input only: go to TWO, with the new payload held in the skid entry.
  - TWO:
    - output: the skid entry moves to main and the state goes to ONE.
    - no input is accepted in TWO.
- in_ready (SKID=1) is registered and equals (state != TWO). It therefore never depends combinationally on out_ready.
- SKID=0: states are EMPTY and ONE only. in_ready = !out_valid || out_ready (combinational).
- Order is strictly FIFO. No payload is duplicated or lost except through flush.
- flush=1 at an edge:
  - the state goes to EMPTY and both entries are invalidated;
  - any in_valid on the same edge is dropped, so flush wins over input;
  - an output transfer on the same edge still counts as delivered.
- Counters:
  - stall_cnt increments on each edge where out_valid=1 and out_ready=0 and flush=0.
  - flush_cnt increments on each flush edge where state != EMPTY.
  - Both saturate at all-ones and never wrap.
- Reset (asserted at any time, including mid-transfer):
  - state goes to EMPTY, out_valid=0, out_data=BUBBLE, in_ready=1, stall_cnt=0, flush_cnt=0;
  - held payloads are discarded.

## Timing
- Latency: a payload accepted at falling edge k appears on out_data with out_valid=1 immediately after edge k (one stage of latency).
- Throughput: one payload per cycle while out_ready=1.
- Backpressure (SKID=1): after out_ready drops, in_ready falls one edge later. The one payload accepted at that edge is held in the skid entry.
- Resume: the first edge with out_ready=1 in TWO frees the skid entry, so in_ready=1 after that edge.
- Reset deassertion is synchronised externally. The first accept can occur on the first falling edge after reset is released.
- Counter values update on the same edge as the event and are readable after it.

## Structure
- Shared package pipe_pkg:
  - state enum {EMPTY, ONE, TWO};
  - constant RV_NOP = 32'h0000_0013;
  - helper function for the saturating increment.
- One sub-module, pipe_sat_counter (CNT_W, inc, clk, reset), instantiated twice for the event counters.
- The skid logic stays in the top module, with a generate branch on SKID.

## Test plan
- Reset mid-stream: hold state TWO, pulse reset low for 3 ns off-edge -> immediately out_valid=0, out_data=32'h13, in_ready=1, counters=0.
- Streaming with out_ready=1, in_data=1,2,3,4 on consecutive edges -> out_data=1,2,3,4 one edge later each, stall_cnt=0.
- Backpressure (SKID=1): stream 10,11,12, hold out_ready=0 for 3 edges after 10 is shown -> 11 held in skid, in_ready=0, 12 held upstream, stall_cnt=3; release out_ready -> 10,11,12 delivered in order, none lost.
- Flush in TWO with in_valid=1, in_data=0x55 on the same edge -> EMPTY, out_data=0x13, 0x55 never appears, flush_cnt=1. A flush while EMPTY leaves flush_cnt unchanged.
- Saturation with CNT_W=4: hold a stall for 20 edges -> stall_cnt stops at 15.
- SKID=0 build: out_ready=0 while ONE -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 -> simultaneous in/out transfer and main entry reloaded.
